pc_sequencer: RTL and testbench

- Program-counter controller that sequences fetch and execute around the branch-decision unit.
- Holds the architectural PC and requests instructions from instruction memory over a req/ready handshake.
- Uses branch_next from the branch comparator plus decoder jump/branch flags to choose the next PC, with flush and misaligned-target trap.
- Sits between the decoder/branch unit and the instruction-memory port.

---
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencer: fetch/exec handshake, branch/jump redirect, misaligned-target trap.
// Optional branch statistics counters (br_count/br_taken) under `ifdef BRANCH_STATS_EN.
module pc_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_PC  = 'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            branch_next,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            flush,
  output logic            trap,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     br_count,
  output logic [31:0]     br_taken,
`endif
  output logic            exec_en
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t state;
  logic   redirect;
  logic   misaligned;

  assign pc_plus4   = pc + XLEN'(4);
  assign imem_addr  = pc;
  // Jump outranks the conditional branch; branch_next only matters for a branch.
  assign redirect   = is_jump | (is_branch & branch_next);
  assign misaligned = (target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
      flush    <= 1'b0;
      trap     <= 1'b0;
      exec_en  <= 1'b0;
`ifdef BRANCH_STATS_EN
      br_count <= 32'd0;
      br_taken <= 32'd0;
`endif
    end else begin
      flush <= 1'b0;
      trap  <= 1'b0;
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready && !stall) begin
            state    <= EXEC;
            imem_req <= 1'b0;
            exec_en  <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            exec_en <= 1'b0;
            if (redirect && misaligned) begin
              pc    <= TRAP_PC;
              flush <= 1'b1;
              trap  <= 1'b1;
              state <= TRAP;
            end else begin
              pc       <= redirect ? target : pc_plus4;
              flush    <= redirect;
              state    <= FETCH;
              imem_req <= 1'b1;
            end
`ifdef BRANCH_STATS_EN
            if (is_branch && (br_count != 32'hFFFF_FFFF))
              br_count <= br_count + 32'd1;
            if (is_branch && redirect && (br_taken != 32'hFFFF_FFFF))
              br_taken <= br_taken + 32'd1;
`endif
          end
        end
        TRAP: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
          exec_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - Instruction-level randomized bench for pc_sequencer.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        stall;
  logic        is_branch;
  logic        is_jump;
  logic        branch_next;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        trap;
  logic        exec_en;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] br_taken;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] model_pc;
  int unsigned exp_cnt = 0;
  int unsigned exp_tk  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .branch_next (branch_next),
    .target      (target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .flush       (flush),
    .trap        (trap),
`ifdef BRANCH_STATS_EN
    .br_count    (br_count),
    .br_taken    (br_taken),
`endif
    .exec_en     (exec_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_decision();
    is_branch   = 1'($urandom);
    is_jump     = 1'($urandom);
    branch_next = 1'($urandom);
    target      = $urandom;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!imem_req && n < 8) begin
      step();
      n++;
    end
    chk("fetch_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  // One instruction: fetch handshake with optional holds, exec with optional stalls, then decision.
  task automatic run_instr(input logic ib, input logic ij, input logic bn, input logic [31:0] tgt,
                           input int fhold, input logic force_ready, input int ehold);
    logic        taken;
    logic        mis;
    logic [31:0] next_pc;
    wait_fetch();
    chk("fetch_addr", imem_addr, model_pc);
    for (int i = 0; i < fhold; i++) begin
      if (force_ready) begin
        imem_ready = 1'b1;
        stall      = 1'b1;
      end else begin
        imem_ready = 1'($urandom);
        stall      = imem_ready ? 1'b1 : 1'($urandom);
      end
      junk_decision();
      step();
      chk("hold_req", {31'd0, imem_req}, 32'd1);
      chk("hold_addr", imem_addr, model_pc);
      chk("hold_exec", {31'd0, exec_en}, 32'd0);
    end
    imem_ready = 1'b1;
    stall      = 1'b0;
    junk_decision();
    step();
    imem_ready = 1'b0;
    chk("exec_en", {31'd0, exec_en}, 32'd1);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    chk("exec_pc", pc, model_pc);
    chk("pc_plus4", pc_plus4, model_pc + 32'd4);
    for (int i = 0; i < ehold; i++) begin
      stall = 1'b1;
      junk_decision();
      step();
      chk("stall_exec_en", {31'd0, exec_en}, 32'd1);
      chk("stall_pc", pc, model_pc);
      chk("stall_flush", {31'd0, flush}, 32'd0);
    end
    stall       = 1'b0;
    is_branch   = ib;
    is_jump     = ij;
    branch_next = bn;
    target      = tgt;
    step();
    taken   = ij || (ib && bn);
    mis     = taken && (tgt[1:0] != 2'b00);
    next_pc = !taken ? model_pc + 32'd4 : (mis ? TRAP_PC : tgt);
    if (ib) begin
      exp_cnt++;
      if (taken) exp_tk++;
    end
    chk("flush", {31'd0, flush}, {31'd0, taken});
    chk("trap", {31'd0, trap}, {31'd0, mis});
    chk("next_pc", pc, next_pc);
    chk("next_req", {31'd0, imem_req}, {31'd0, !mis});
    chk("exec_drop", {31'd0, exec_en}, 32'd0);
    junk_decision();
    if (mis) begin
      step();
      chk("trap_pulse", {31'd0, trap}, 32'd0);
      chk("flush_pulse", {31'd0, flush}, 32'd0);
    end
    model_pc = next_pc;
  endtask

  task automatic check_stats();
`ifdef BRANCH_STATS_EN
    chk("br_count", br_count, exp_cnt);
    chk("br_taken", br_taken, exp_tk);
`endif
  endtask

  initial begin
    logic [31:0] t;
    rst = 1'b1; imem_ready = 1'b0; stall = 1'b0;
    is_branch = 1'b0; is_jump = 1'b0; branch_next = 1'b0; target = 32'd0;
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_exec", {31'd0, exec_en}, 32'd0);
    check_stats();
    rst = 1'b0;
    model_pc = RESET_PC;

    for (int i = 0; i < 4; i++) run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0040, 0, 1'b1, 0);
    run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0040, 0, 1'b1, 0);
    run_instr(1'b1, 1'b0, 1'b0, 32'h0000_0200, 0, 1'b1, 0);
    run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0080, 0, 1'b1, 0);
    run_instr(1'b0, 1'b1, 1'b0, 32'h0000_0020, 0, 1'b1, 0);
    run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0042, 3, 1'b1, 0);
    run_instr(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 0, 1'b1, 1);
    run_instr(1'b0, 1'b0, 1'b0, 32'h0000_0000, 0, 1'b1, 0);
    chk("wrap_pc", model_pc, pc);
    check_stats();

    for (int i = 0; i < 60; i++) begin
      t = $urandom;
      if (($urandom % 4) != 0) t[1:0] = 2'b00;
      run_instr(1'($urandom), 1'(($urandom % 4) == 0), 1'($urandom), t,
                int'($urandom_range(0, 3)), 1'b0, int'($urandom_range(0, 2)));
    end
    check_stats();

    wait_fetch();
    imem_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_ready = 1'b0;
    chk("midfetch_rst_req", {31'd0, imem_req}, 32'd0);
    chk("midfetch_rst_pc", pc, RESET_PC);
    chk("midfetch_rst_exec", {31'd0, exec_en}, 32'd0);
    exp_cnt = 0;
    exp_tk  = 0;
    check_stats();
    model_pc = RESET_PC;
    run_instr(1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
